// File: rtl/pc_unit.sv
// pc_unit: registered program counter with a circular return-address stack.
// The optional macro PC_TRAP_EN selects how stack faults are handled.
//   With PC_TRAP_EN defined, a CALL on a full stack or a RET on an empty
//   stack jumps to TRAP_VECTOR and sets the sticky err flag.
//   Without it, a CALL on a full stack overwrites the oldest entry, a RET on
//   an empty stack behaves as INC, and err is held at 0.
module pc_unit #(
  parameter int               WIDTH        = 12,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(12'hFF0)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [1:0]                     op,
  input  logic [WIDTH-1:0]               target,
  output logic [WIDTH-1:0]               pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           err
);

  localparam int PTRW = $clog2(RAS_DEPTH);
  localparam int CNTW = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } opT;

  // topPtr is the next free slot, so the most recent entry sits at topPtr-1.
  // When the stack is full, topPtr also points at the oldest entry.
  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PTRW-1:0]  topPtr;
  logic [PTRW-1:0]  topIdx;
  logic [PTRW-1:0]  ptrNext;
  logic [CNTW-1:0]  countNext;
  logic [WIDTH-1:0] pcNext;
  logic [WIDTH-1:0] seqPc;
  logic             doPush;
`ifdef PC_TRAP_EN
  logic             errSet;
  logic             errReg;
`endif

  assign seqPc     = pc + STEP_W;
  assign topIdx    = topPtr - 1'b1;
  assign ras_full  = (ras_count == CNTW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  // Decode the requested operation into next pc, stack pointer and count.
  always_comb begin
    pcNext    = pc;
    ptrNext   = topPtr;
    countNext = ras_count;
    doPush    = 1'b0;
`ifdef PC_TRAP_EN
    errSet    = 1'b0;
`endif
    if (en) begin
      case (opT'(op))
        OP_INC: pcNext = seqPc;
        OP_JUMP: pcNext = target;
        OP_CALL: begin
          if (!ras_full) begin
            doPush    = 1'b1;
            ptrNext   = topPtr + 1'b1;
            countNext = ras_count + 1'b1;
            pcNext    = target;
          end else begin
`ifdef PC_TRAP_EN
            pcNext = TRAP_VECTOR;
            errSet = 1'b1;
`else
            doPush  = 1'b1;
            ptrNext = topPtr + 1'b1;
            pcNext  = target;
`endif
          end
        end
        OP_RET: begin
          if (!ras_empty) begin
            pcNext    = stack[topIdx];
            ptrNext   = topIdx;
            countNext = ras_count - 1'b1;
          end else begin
`ifdef PC_TRAP_EN
            pcNext = TRAP_VECTOR;
            errSet = 1'b1;
`else
            pcNext = seqPc;
`endif
          end
        end
      endcase
    end
  end

  // Control state: pc, stack pointer and entry count, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      topPtr    <= '0;
      ras_count <= '0;
    end else begin
      pc        <= pcNext;
      topPtr    <= ptrNext;
      ras_count <= countNext;
    end
  end

  // Stack storage carries no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (doPush) begin
      stack[topPtr] <= seqPc;
    end
  end

`ifdef PC_TRAP_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errReg <= 1'b0;
    end else if (errSet) begin
      errReg <= 1'b1;
    end
  end

  assign err = errReg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test of pc_unit with a queue-based reference model.
// Build with or without +define+PC_TRAP_EN; expectations follow the macro.
module tb_pc_unit;

  localparam logic [1:0] INC  = 2'b00;
  localparam logic [1:0] JUMP = 2'b01;
  localparam logic [1:0] CALL = 2'b10;
  localparam logic [1:0] RET  = 2'b11;
  localparam int DEPTH = 4;
  localparam logic [11:0] TRAP = 12'hFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  op;
  logic [11:0] target;
  logic [11:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Reference model: pc value, return addresses as a queue, sticky fault flag.
  logic [11:0] mPc  = 12'h000;
  logic        mErr = 1'b0;
  logic [11:0] mStack [$];

  pc_unit #(
    .WIDTH(12), .STEP(1), .RESET_VECTOR(12'h000), .RAS_DEPTH(DEPTH), .TRAP_VECTOR(TRAP)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .target(target),
    .pc(pc), .ras_count(ras_count), .ras_full(ras_full),
    .ras_empty(ras_empty), .err(err)
  );

  always #5 clk = ~clk;

  // Model advances on the same edges as the design, from the specified rules.
  always @(posedge clk or posedge reset) begin
    logic [11:0] nxt;
    if (reset) begin
      mPc  = 12'h000;
      mErr = 1'b0;
      mStack.delete();
    end else if (en) begin
      nxt = mPc + 12'd1;
      case (op)
        INC:  mPc = nxt;
        JUMP: mPc = target;
        CALL: begin
          if (mStack.size() < DEPTH) begin
            mStack.push_back(nxt);
            mPc = target;
          end else begin
`ifdef PC_TRAP_EN
            mPc  = TRAP;
            mErr = 1'b1;
`else
            void'(mStack.pop_front());
            mStack.push_back(nxt);
            mPc = target;
`endif
          end
        end
        default: begin
          if (mStack.size() > 0) begin
            mPc = mStack.pop_back();
          end else begin
`ifdef PC_TRAP_EN
            mPc  = TRAP;
            mErr = 1'b1;
`else
            mPc = nxt;
`endif
          end
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, compare all outputs with the model away from the rising edge.
  always @(negedge clk) begin
    checkOutput("cyc_pc", 32'(pc), 32'(mPc));
    checkOutput("cyc_count", 32'(ras_count), 32'(mStack.size()));
    checkOutput("cyc_full", 32'(ras_full), 32'(mStack.size() == DEPTH));
    checkOutput("cyc_empty", 32'(ras_empty), 32'(mStack.size() == 0));
    checkOutput("cyc_err", 32'(err), 32'(mErr));
  end

  task automatic applyStimulus(input logic e, input logic [1:0] o, input logic [11:0] t);
    @(negedge clk);
    en     = e;
    op     = o;
    target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    op     = INC;
    target = 12'h000;
    #12;
    checkOutput("rst_pc", 32'(pc), 32'h000);
    checkOutput("rst_count", 32'(ras_count), 32'd0);
    checkOutput("rst_empty", 32'(ras_empty), 32'd1);
    checkOutput("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential increment, then stall with an op that would otherwise jump.
    applyStimulus(1'b1, INC, 12'h000);  checkOutput("inc1", 32'(pc), 32'h001);
    applyStimulus(1'b1, INC, 12'h000);  checkOutput("inc2", 32'(pc), 32'h002);
    applyStimulus(1'b1, INC, 12'h000);  checkOutput("inc3", 32'(pc), 32'h003);
    applyStimulus(1'b0, JUMP, 12'hABC); checkOutput("stall1", 32'(pc), 32'h003);
    applyStimulus(1'b0, CALL, 12'h123); checkOutput("stall2", 32'(pc), 32'h003);
    checkOutput("stall_empty", 32'(ras_empty), 32'd1);

    // Jump near the top of the address space and wrap silently.
    applyStimulus(1'b1, JUMP, 12'hFFE); checkOutput("jump", 32'(pc), 32'hFFE);
    applyStimulus(1'b1, INC, 12'h000);  checkOutput("inc_fff", 32'(pc), 32'hFFF);
    applyStimulus(1'b1, INC, 12'h000);  checkOutput("wrap", 32'(pc), 32'h000);

    // Call, step inside the callee, return to the instruction after the call.
    applyStimulus(1'b1, JUMP, 12'h010);
    applyStimulus(1'b1, CALL, 12'h100); checkOutput("call_pc", 32'(pc), 32'h100);
    checkOutput("call_count", 32'(ras_count), 32'd1);
    applyStimulus(1'b1, INC, 12'h000);  checkOutput("callee_inc", 32'(pc), 32'h101);
    applyStimulus(1'b1, RET, 12'h000);  checkOutput("ret_pc", 32'(pc), 32'h011);
    checkOutput("ret_count", 32'(ras_count), 32'd0);
    checkOutput("ret_empty", 32'(ras_empty), 32'd1);

    // Fill the stack and overflow it with a fifth call.
    applyStimulus(1'b1, JUMP, 12'h000);
    applyStimulus(1'b1, CALL, 12'h100);
    applyStimulus(1'b1, CALL, 12'h200);
    applyStimulus(1'b1, CALL, 12'h300);
    applyStimulus(1'b1, CALL, 12'h400);
    checkOutput("full_flag", 32'(ras_full), 32'd1);
    applyStimulus(1'b1, CALL, 12'h500);
    checkOutput("ovf_count", 32'(ras_count), 32'd4);
`ifdef PC_TRAP_EN
    checkOutput("ovf_pc", 32'(pc), 32'hFF0);
    checkOutput("ovf_err", 32'(err), 32'd1);
    applyStimulus(1'b1, RET, 12'h000); checkOutput("ovf_ret1", 32'(pc), 32'h301);
    applyStimulus(1'b1, RET, 12'h000); checkOutput("ovf_ret2", 32'(pc), 32'h201);
    applyStimulus(1'b1, RET, 12'h000); checkOutput("ovf_ret3", 32'(pc), 32'h101);
    applyStimulus(1'b1, RET, 12'h000); checkOutput("ovf_ret4", 32'(pc), 32'h001);
    checkOutput("ovf_err_sticky", 32'(err), 32'd1);
`else
    checkOutput("ovf_pc", 32'(pc), 32'h500);
    checkOutput("ovf_err", 32'(err), 32'd0);
    applyStimulus(1'b1, RET, 12'h000); checkOutput("ovf_ret1", 32'(pc), 32'h401);
    applyStimulus(1'b1, RET, 12'h000); checkOutput("ovf_ret2", 32'(pc), 32'h301);
    applyStimulus(1'b1, RET, 12'h000); checkOutput("ovf_ret3", 32'(pc), 32'h201);
    applyStimulus(1'b1, RET, 12'h000); checkOutput("ovf_ret4", 32'(pc), 32'h101);
`endif
    checkOutput("ovf_drained", 32'(ras_count), 32'd0);

    // Return with an empty stack from a clean state.
    doReset();
    checkOutput("rst2_err", 32'(err), 32'd0);
    applyStimulus(1'b1, JUMP, 12'h020);
    applyStimulus(1'b1, RET, 12'h000);
`ifdef PC_TRAP_EN
    checkOutput("udf_pc", 32'(pc), 32'hFF0);
    checkOutput("udf_err", 32'(err), 32'd1);
    applyStimulus(1'b1, INC, 12'h000);  checkOutput("udf_err_inc", 32'(err), 32'd1);
    applyStimulus(1'b1, JUMP, 12'h040); checkOutput("udf_err_jump", 32'(err), 32'd1);
    checkOutput("udf_pc_jump", 32'(pc), 32'h040);
`else
    checkOutput("udf_pc", 32'(pc), 32'h021);
    checkOutput("udf_err", 32'(err), 32'd0);
`endif
    checkOutput("udf_count", 32'(ras_count), 32'd0);

    // Asynchronous reset between edges discards the stacked calls.
    doReset();
    applyStimulus(1'b1, CALL, 12'h050);
    applyStimulus(1'b1, CALL, 12'h060);
    checkOutput("pre_rst_count", 32'(ras_count), 32'd2);
    #2;
    reset = 1'b1;
    en    = 1'b0;
    #1;
    checkOutput("async_pc", 32'(pc), 32'h000);
    checkOutput("async_count", 32'(ras_count), 32'd0);
    checkOutput("async_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, INC, 12'h000); checkOutput("post_rst_inc", 32'(pc), 32'h001);
    checkOutput("post_rst_empty", 32'(ras_empty), 32'd1);
    applyStimulus(1'b0, INC, 12'h000);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
